// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types, defaults and the rotating-priority pick used by the round-robin
// grant scheduler.
package sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_IDX_W    = 3;
    localparam int DEF_MAX_HOLD = 16;
    localparam int MAX_IDX_W    = 8;
    localparam int MAX_N        = 1 << MAX_IDX_W;

    // First set bit of req searching ptr, ptr+1, ... modulo 2^idx_w.
    function automatic int unsigned rr_pick(input logic [MAX_N-1:0] req,
                                            input int unsigned      ptr,
                                            input int unsigned      idx_w);
        int unsigned n;
        int unsigned cand;
        logic        found;
        n       = 32'd1 << idx_w;
        found   = 1'b0;
        rr_pick = 0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            cand = (ptr + k) & (n - 32'd1);
            if (!found && (k < n) && req[cand[MAX_IDX_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Requester-side bundle of the grant scheduler: requests and release in,
// grant vector, index, valid and timeout pulse out.
interface rr_grant_scheduler_if #(
    parameter int IDX_W = sched_pkg::DEF_IDX_W
);
    localparam int N = 1 << IDX_W;

    logic [N-1:0]     req;
    logic             release_i;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, release_i,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, release_i,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_grant_scheduler_onehot_decoder.sv
// Combinational binary-to-one-hot decoder; N is the width of the binary index.
module onehot_decoder #(
    parameter int N = 3
) (
    input  logic [N-1:0]        in_i,
    output logic [(1<<N)-1:0]   out_o
);
    always_comb begin
        out_o       = '0;
        out_o[in_i] = 1'b1;
    end
endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter: registered grant index held until release, withdrawal
// or hold timeout, with one dead cycle between consecutive owners.
module rr_grant_scheduler
    import sched_pkg::*;
#(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_grant_scheduler_if.slave bus
);
    localparam int N     = 1 << IDX_W;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [N-1:0]     dec_out;
    logic             owner_req;
    logic             hold_expired;

    assign owner_req    = bus.req[gnt_idx_q];
    assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD));

    // NOTE: every next-state signal is defaulted first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_idx_d = IDX_W'(rr_pick(MAX_N'(bus.req), 32'(ptr_q), IDX_W));
                    cnt_d     = CNT_W'(1);
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (bus.release_i || !owner_req || hold_expired) begin
                    // Only a revocation with the owner still asking pulses timeout.
                    timeout_d = !bus.release_i && owner_req;
                    ptr_d     = gnt_idx_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    onehot_decoder #(.N(IDX_W)) u_dec (
        .in_i  (gnt_idx_q),
        .out_o (dec_out)
    );

    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt       = dec_out & {N{bus.gnt_valid}};
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.timeout   = timeout_q;
endmodule
